// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage MIPS pipeline. Issues the dcache load/store
//   for the instruction in the EX latch, resolves BEQ/BNE mispredictions, and
//   latches the writeback result into the MEM/WB register.
// Latency: dcache requests and branch resolution are combinational from ex_*.
//   MEM/WB updates on the first edge where ihit is high, freeze is low and the
//   memory op has completed.
// Backpressure: mem_stall holds the pipeline while a memory op waits for dhit.
//   freeze or a missing ihit holds the MEM/WB latch. A completed op parks in DONE
//   with its load data in load_buf, so the request is never re-issued.
// Ports:
//   CLK, nRST                   clock; async active-low reset
//   ex_*                        execute pipeline latch
//   ihit, freeze                pipeline advance strobe, hazard-unit hold
//   dhit, dmemload              dcache completion strobe and load data
//   dmemREN/WEN/addr/store      dcache request
//   mem_stall                   memory op outstanding
//   mispredict, redirect_pc     branch flush and corrected fetch PC
//   FW_mem_data                 MEM-stage forwarding source
//   mem_valid/Rw/RegWEN/halt/wdata  MEM/WB latch
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_BEQ,
  input  logic              ex_BNE,
  input  logic              ex_zero,
  input  logic              ex_branch_taken,
  input  logic [WORD_W-1:0] ex_PC,
  input  logic [WORD_W-1:0] ex_Imm_Ext,
  input  logic [WORD_W-1:0] ex_port_o,
  input  logic [WORD_W-1:0] ex_port_b,
  input  logic [REG_AW-1:0] ex_Rw,
  input  logic              ex_RegWEN,
  input  logic              ex_MemtoReg,
  input  logic              ex_halt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              freeze,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              mispredict,
  output logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] FW_mem_data,
  output logic              mem_valid,
  output logic              mem_RegWEN,
  output logic              mem_halt,
  output logic [REG_AW-1:0] mem_Rw,
  output logic [WORD_W-1:0] mem_wdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DONE   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] load_buf;

  logic              memop;
  logic              in_idle;
  logic              adv;
  logic              taken;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] wb_value;

  assign memop   = ex_valid & (ex_dREN | ex_dWEN);
  assign in_idle = (state == IDLE);

  // Requests are qualified by nRST so that they fall the instant reset is
  // asserted, even while the EX latch still presents a memory op.
  assign dmemREN   = nRST & memop & ex_dREN & in_idle;
  assign dmemWEN   = nRST & memop & ex_dWEN & in_idle;
  assign dmemaddr  = {ex_port_o[WORD_W-1:2], 2'b00};
  assign dmemstore = ex_port_b;

  // A dhit in the same cycle clears the stall so the op can retire at once.
  assign mem_stall = nRST & memop & in_idle & ~dhit;

  assign adv = ihit & ~freeze & ~mem_stall & (state != HALTED);

  // Branch resolution. The branch target wraps modulo 2^WORD_W.
  assign taken       = (ex_BEQ & ex_zero) | (ex_BNE & ~ex_zero);
  assign pc_plus4    = ex_PC + WORD_W'(4);
  assign redirect_pc = taken ? (pc_plus4 + (ex_Imm_Ext << 2)) : pc_plus4;
  assign mispredict  = nRST & ex_valid & (ex_BEQ | ex_BNE) &
                       (taken != ex_branch_taken) & (state != HALTED);

  assign FW_mem_data = ex_port_o;

  // Load data comes from load_buf once the op has parked in DONE, otherwise
  // straight from the dcache (dhit and ihit in the same cycle).
  assign wb_value = ex_MemtoReg ? ((state == DONE) ? load_buf : dmemload)
                                : ex_port_o;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      load_buf   <= '0;
      mem_valid  <= 1'b0;
      mem_RegWEN <= 1'b0;
      mem_halt   <= 1'b0;
      mem_Rw     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && dhit) begin
            load_buf <= dmemload;
          end
          if (adv) begin
            mem_valid  <= ex_valid;
            mem_Rw     <= ex_valid ? ex_Rw : '0;
            mem_RegWEN <= ex_valid & ex_RegWEN;
            mem_halt   <= ex_valid & ex_halt;
            mem_wdata  <= wb_value;
            state      <= (ex_valid & ex_halt) ? HALTED : IDLE;
          end else if (memop && dhit) begin
            state <= DONE;
          end
        end
        DONE: begin
          // load_buf holds while frozen; no new request is raised from here.
          if (adv) begin
            mem_valid  <= ex_valid;
            mem_Rw     <= ex_valid ? ex_Rw : '0;
            mem_RegWEN <= ex_valid & ex_RegWEN;
            mem_halt   <= ex_valid & ex_halt;
            mem_wdata  <= wb_value;
            state      <= (ex_valid & ex_halt) ? HALTED : IDLE;
          end
        end
        HALTED: begin
          // Sticky until reset; the MEM/WB latch stays frozen.
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        CLK;
  logic        nRST;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_BEQ, ex_BNE, ex_zero, ex_branch_taken;
  logic [31:0] ex_PC, ex_Imm_Ext, ex_port_o, ex_port_b;
  logic [4:0]  ex_Rw;
  logic        ex_RegWEN, ex_MemtoReg, ex_halt;
  logic        ihit, dhit, freeze;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall, mispredict;
  logic [31:0] dmemaddr, dmemstore, redirect_pc, FW_mem_data, mem_wdata;
  logic        mem_valid, mem_RegWEN, mem_halt;
  logic [4:0]  mem_Rw;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rw;
    logic        regwen;
    logic        halt;
    logic [31:0] wdata;
  } wb_t;

  wb_t sb[$];
  wb_t exp_wb;
  wb_t obs_wb;

  int pass_cnt = 0;
  int total_cnt = 0;

  memory_stage #(.WORD_W(32), .REG_AW(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_BEQ(ex_BEQ), .ex_BNE(ex_BNE), .ex_zero(ex_zero),
    .ex_branch_taken(ex_branch_taken), .ex_PC(ex_PC), .ex_Imm_Ext(ex_Imm_Ext),
    .ex_port_o(ex_port_o), .ex_port_b(ex_port_b), .ex_Rw(ex_Rw),
    .ex_RegWEN(ex_RegWEN), .ex_MemtoReg(ex_MemtoReg), .ex_halt(ex_halt),
    .ihit(ihit), .dhit(dhit), .dmemload(dmemload), .freeze(freeze),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .FW_mem_data(FW_mem_data),
    .mem_valid(mem_valid), .mem_RegWEN(mem_RegWEN), .mem_halt(mem_halt),
    .mem_Rw(mem_Rw), .mem_wdata(mem_wdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_ex(input logic dren, input logic dwen, input logic [31:0] port_o,
                        input logic [31:0] port_b, input logic [4:0] rw,
                        input logic regwen, input logic memtoreg, input logic halt);
    ex_valid    = 1'b1;
    ex_dREN     = dren;
    ex_dWEN     = dwen;
    ex_port_o   = port_o;
    ex_port_b   = port_b;
    ex_Rw       = rw;
    ex_RegWEN   = regwen;
    ex_MemtoReg = memtoreg;
    ex_halt     = halt;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_halt = 1'b0;
    ex_BEQ = 1'b0; ex_BNE = 1'b0; ex_zero = 1'b0; ex_branch_taken = 1'b0;
    ex_RegWEN = 1'b0; ex_MemtoReg = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_ex();
    ex_PC = 32'h0; ex_Imm_Ext = 32'h0; ex_port_o = 32'h0; ex_port_b = 32'h0; ex_Rw = 5'd0;
    ihit = 1'b0; dhit = 1'b0; freeze = 1'b0; dmemload = 32'h0;
    // A pending load and a mispredicting branch while reset is held.
    set_ex(1'b1, 1'b0, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
    ex_BEQ = 1'b1; ex_zero = 1'b1;
    #3;
    total_cnt++;
    if ({dmemREN, dmemWEN, mispredict, mem_stall} !== 4'b0000)
      $display("FAIL reset_req: got %b want 0000", {dmemREN, dmemWEN, mispredict, mem_stall});
    else pass_cnt++;
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== '0) $display("FAIL reset_latch: got %h want 0", obs_wb);
    else pass_cnt++;
    clear_ex();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_lw();
    int ren_cnt = 0;
    set_ex(1'b1, 1'b0, 32'h0000_0104, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    sb.push_back('{valid: 1'b1, rw: 5'd5, regwen: 1'b1, halt: 1'b0, wdata: 32'hDEAD_BEEF});
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      dhit = (c == 2);
      dmemload = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
      ihit = (c == 4);
      #1;
      if (dmemREN) ren_cnt++;
      if (c == 0) begin
        total_cnt++;
        if (dmemaddr !== 32'h104) $display("FAIL lw_addr: got %h want 00000104", dmemaddr);
        else pass_cnt++;
        total_cnt++;
        if (mem_stall !== 1'b1) $display("FAIL lw_stall_wait: got %b want 1", mem_stall);
        else pass_cnt++;
      end
      if (c == 3) begin
        total_cnt++;
        if (mem_stall !== 1'b0) $display("FAIL lw_stall_after_dhit: got %b want 0", mem_stall);
        else pass_cnt++;
      end
      @(posedge CLK);
      #1;
    end
    exp_wb = sb.pop_front();
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== exp_wb) $display("FAIL lw_retire: got %h want %h", obs_wb, exp_wb);
    else pass_cnt++;
    total_cnt++;
    if (ren_cnt != 3) $display("FAIL lw_ren_cycles: got %0d want 3", ren_cnt);
    else pass_cnt++;
    clear_ex(); ihit = 1'b0; dhit = 1'b0;
  endtask

  task automatic test_sw();
    int wen_cnt = 0;
    @(negedge CLK);
    set_ex(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd7, 1'b0, 1'b0, 1'b0);
    sb.push_back('{valid: 1'b1, rw: 5'd7, regwen: 1'b0, halt: 1'b0, wdata: 32'h0000_0200});
    #1;
    if (dmemWEN) wen_cnt++;
    total_cnt++;
    if (dmemstore !== 32'h1234_5678) $display("FAIL sw_store: got %h want 12345678", dmemstore);
    else pass_cnt++;
    @(negedge CLK);
    dhit = 1'b1; ihit = 1'b1;
    #1;
    if (dmemWEN) wen_cnt++;
    total_cnt++;
    if (mem_stall !== 1'b0) $display("FAIL sw_stall_dhit: got %b want 0", mem_stall);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    exp_wb = sb.pop_front();
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== exp_wb) $display("FAIL sw_retire: got %h want %h", obs_wb, exp_wb);
    else pass_cnt++;
    total_cnt++;
    if (wen_cnt != 2) $display("FAIL sw_wen_cycles: got %0d want 2", wen_cnt);
    else pass_cnt++;
    clear_ex(); dhit = 1'b0; ihit = 1'b0;
    @(negedge CLK);
    #1;
    total_cnt++;
    if ({dmemWEN, mem_stall} !== 2'b00) $display("FAIL sw_no_rerequest: got %b want 00", {dmemWEN, mem_stall});
    else pass_cnt++;
  endtask

  task automatic test_freeze_done();
    @(negedge CLK);
    set_ex(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    sb.push_back('{valid: 1'b1, rw: 5'd9, regwen: 1'b1, halt: 1'b0, wdata: 32'hA5A5_A5A5});
    dhit = 1'b1; dmemload = 32'hA5A5_A5A5; ihit = 1'b0;
    @(negedge CLK);
    dhit = 1'b0; dmemload = 32'h1111_1111; ihit = 1'b1; freeze = 1'b1;
    #1;
    total_cnt++;
    if ({dmemREN, mem_stall} !== 2'b00) $display("FAIL done_no_rerequest: got %b want 00", {dmemREN, mem_stall});
    else pass_cnt++;
    @(posedge CLK);
    #1;
    total_cnt++;
    if (mem_wdata !== 32'h0000_0200) $display("FAIL freeze_hold: got %h want 00000200", mem_wdata);
    else pass_cnt++;
    @(negedge CLK);
    freeze = 1'b0; dmemload = 32'h2222_2222;
    @(posedge CLK);
    #1;
    exp_wb = sb.pop_front();
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== exp_wb) $display("FAIL freeze_retire: got %h want %h", obs_wb, exp_wb);
    else pass_cnt++;
    clear_ex(); ihit = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_tbl[2];
    logic [31:0] data_tbl[2];
    logic [31:0] waddr_tbl[2];
    addr_tbl[0] = 32'h0000_0400; data_tbl[0] = 32'hCAFE_0001; waddr_tbl[0] = 32'h0000_0400;
    addr_tbl[1] = 32'h0000_0407; data_tbl[1] = 32'hCAFE_0002; waddr_tbl[1] = 32'h0000_0404;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      set_ex(1'b1, 1'b0, addr_tbl[i], 32'h0, 5'(10 + i), 1'b1, 1'b1, 1'b0);
      sb.push_back('{valid: 1'b1, rw: 5'(10 + i), regwen: 1'b1, halt: 1'b0, wdata: data_tbl[i]});
      dhit = 1'b1; ihit = 1'b1; dmemload = data_tbl[i];
      #1;
      total_cnt++;
      if (dmemaddr !== waddr_tbl[i]) $display("FAIL b2b_addr%0d: got %h want %h", i, dmemaddr, waddr_tbl[i]);
      else pass_cnt++;
      total_cnt++;
      if (FW_mem_data !== addr_tbl[i]) $display("FAIL b2b_fwd%0d: got %h want %h", i, FW_mem_data, addr_tbl[i]);
      else pass_cnt++;
      @(posedge CLK);
      #1;
      exp_wb = sb.pop_front();
      obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
      total_cnt++;
      if (obs_wb !== exp_wb) $display("FAIL b2b_retire%0d: got %h want %h", i, obs_wb, exp_wb);
      else pass_cnt++;
    end
    clear_ex(); dhit = 1'b0; ihit = 1'b0;
  endtask

  task automatic test_branch();
    // valid, beq, bne, zero, pred, pc, imm, expected mispredict, expected redirect
    typedef struct packed {
      logic v, beq, bne, z, pred;
      logic [31:0] pc, imm;
      logic mis;
      logic [31:0] rpc;
    } br_t;
    br_t tbl[6];
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h3,         1'b1, 32'h50};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40,  32'h3,         1'b0, 32'h50};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7C,  32'h10,        1'b1, 32'h80};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7C,  32'hFFFF_FFFF, 1'b0, 32'h7C};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h8,         1'b0, 32'h104};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h1,         1'b0, 32'h208};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      clear_ex();
      ex_valid = tbl[i].v; ex_BEQ = tbl[i].beq; ex_BNE = tbl[i].bne;
      ex_zero = tbl[i].z; ex_branch_taken = tbl[i].pred;
      ex_PC = tbl[i].pc; ex_Imm_Ext = tbl[i].imm;
      #1;
      total_cnt++;
      if (mispredict !== tbl[i].mis) $display("FAIL br_mispredict%0d: got %b want %b", i, mispredict, tbl[i].mis);
      else pass_cnt++;
      total_cnt++;
      if (redirect_pc !== tbl[i].rpc) $display("FAIL br_redirect%0d: got %h want %h", i, redirect_pc, tbl[i].rpc);
      else pass_cnt++;
    end
    clear_ex();
  endtask

  task automatic test_halt();
    @(negedge CLK);
    set_ex(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    sb.push_back('{valid: 1'b1, rw: 5'd0, regwen: 1'b0, halt: 1'b1, wdata: 32'h0});
    ihit = 1'b1;
    @(posedge CLK);
    #1;
    exp_wb = sb.pop_front();
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== exp_wb) $display("FAIL halt_retire: got %h want %h", obs_wb, exp_wb);
    else pass_cnt++;
    // A load plus a mispredicting branch presented while halted.
    set_ex(1'b1, 1'b0, 32'h500, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    ex_BEQ = 1'b1; ex_zero = 1'b1; ex_branch_taken = 1'b0;
    dhit = 1'b1; dmemload = 32'h9999_9999;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      total_cnt++;
      if ({dmemREN, mispredict} !== 2'b00) $display("FAIL halted_quiet%0d: got %b want 00", c, {dmemREN, mispredict});
      else pass_cnt++;
      @(posedge CLK);
      #1;
      total_cnt++;
      if ({mem_halt, mem_Rw, mem_wdata} !== {1'b1, 5'd0, 32'h0})
        $display("FAIL halted_sticky%0d: got %b/%h/%h want 1/00/00000000", c, mem_halt, mem_Rw, mem_wdata);
      else pass_cnt++;
    end
    ex_BEQ = 1'b0; ex_zero = 1'b0; dhit = 1'b0; ihit = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    total_cnt++;
    if ({mem_valid, mem_halt, mem_RegWEN, dmemREN, mispredict} !== 5'b00000)
      $display("FAIL halt_reset: got %b want 00000", {mem_valid, mem_halt, mem_RegWEN, dmemREN, mispredict});
    else pass_cnt++;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    total_cnt++;
    if (dmemREN !== 1'b1) $display("FAIL halt_reset_idle: got %b want 1", dmemREN);
    else pass_cnt++;
    sb.push_back('{valid: 1'b1, rw: 5'd3, regwen: 1'b1, halt: 1'b0, wdata: 32'h5151_5151});
    dhit = 1'b1; ihit = 1'b1; dmemload = 32'h5151_5151;
    @(posedge CLK);
    #1;
    exp_wb = sb.pop_front();
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== exp_wb) $display("FAIL halt_reset_retire: got %h want %h", obs_wb, exp_wb);
    else pass_cnt++;
    clear_ex(); dhit = 1'b0; ihit = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    set_ex(1'b1, 1'b0, 32'h600, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0);
    #1;
    total_cnt++;
    if (dmemREN !== 1'b1) $display("FAIL mid_req: got %b want 1", dmemREN);
    else pass_cnt++;
    #1;
    nRST = 1'b0;
    #1;
    total_cnt++;
    if ({dmemREN, mem_stall} !== 2'b00) $display("FAIL mid_async_drop: got %b want 00", {dmemREN, mem_stall});
    else pass_cnt++;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    total_cnt++;
    if ({dmemREN, mem_stall, dmemaddr} !== {2'b11, 32'h600})
      $display("FAIL mid_reissue: got %b%b/%h want 11/00000600", dmemREN, mem_stall, dmemaddr);
    else pass_cnt++;
    sb.push_back('{valid: 1'b1, rw: 5'd12, regwen: 1'b1, halt: 1'b0, wdata: 32'h6060_6060});
    dhit = 1'b1; ihit = 1'b1; dmemload = 32'h6060_6060;
    @(posedge CLK);
    #1;
    exp_wb = sb.pop_front();
    obs_wb = {mem_valid, mem_Rw, mem_RegWEN, mem_halt, mem_wdata};
    total_cnt++;
    if (obs_wb !== exp_wb) $display("FAIL mid_retire: got %h want %h", obs_wb, exp_wb);
    else pass_cnt++;
    clear_ex(); dhit = 1'b0; ihit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_freeze_done();
    test_back_to_back();
    test_branch();
    test_halt();
    test_reset_mid();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
